// File: rtl/hyperram_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// hyperram_arbiter_pkg
// Shared constants for the HyperRAM arbiter and its op controller:
//   - op controller opcodes (oOpReq encoding)
//   - arbiter FSM state encodings
//   - bus widths and a helper that maps a granted port to its memory opcode
// ---------------------------------------------------------------------------
package hyperram_arbiter_pkg;

    localparam int ADDR_W = 23;
    localparam int DATA_W = 128;

    // Opcodes understood by the HyperRAM op controller
    localparam logic [2:0] OP_HW_RESET = 3'b000;
    localparam logic [2:0] OP_RD_REG   = 3'b001;
    localparam logic [2:0] OP_WR_REG   = 3'b010;
    localparam logic [2:0] OP_RD_MEM   = 3'b011;
    localparam logic [2:0] OP_WR_MEM   = 3'b100;

    // Arbiter FSM states
    localparam logic [2:0] ST_POR_WAIT = 3'd0;
    localparam logic [2:0] ST_INIT_RST = 3'd1;
    localparam logic [2:0] ST_INIT_CFG = 3'd2;
    localparam logic [2:0] ST_IDLE     = 3'd3;
    localparam logic [2:0] ST_ISSUE    = 3'd4;
    localparam logic [2:0] ST_RELEASE  = 3'd5;

    // Memory opcode for the granted requester
    function automatic logic [2:0] mem_opcode(input logic is_write);
        return is_write ? OP_WR_MEM : OP_RD_MEM;
    endfunction

endpackage

// File: rtl/hyperram_arbiter.sv
// ---------------------------------------------------------------------------
// hyperram_arbiter
// Arbitrates one write requester and one read requester onto a HyperRAM op
// controller. After reset it waits POR_CYCLES, issues a HW reset op and a
// register-write (config) op, then serves requests round-robin. Each issued
// op is bounded by TIMEOUT_CYCLES; a timeout sets the sticky oErr and still
// acknowledges the requester so nothing upstream stalls.
//
// Ports
//   iClk, iRstN              clock, asynchronous active-low reset
//   iWrReq/iWrAddr/iWrData   write request (held until oWrAck), addr/data
//   oWrAck                   1-cycle pulse, write completed
//   iRdReq/iRdAddr           read request (held until oRdAck), addr
//   oRdAck/oRdData           1-cycle pulse, registered read data
//   oEn/oOpReq               op enable and opcode to the op controller
//   oOpMemAddr/oOpMemData    address/write data for the issued op
//   iRdData/iOpDone          read data and completion from the op controller
//   oReady                   init sequence finished, accepting requests
//   oErr                     sticky: some op timed out
// ---------------------------------------------------------------------------
module hyperram_arbiter
    import hyperram_arbiter_pkg::*;
#(
    parameter int POR_CYCLES     = 32768,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic         iClk,
    input  logic         iRstN,
    input  logic         iWrReq,
    input  logic [22:0]  iWrAddr,
    input  logic [127:0] iWrData,
    output logic         oWrAck,
    input  logic         iRdReq,
    input  logic [22:0]  iRdAddr,
    output logic         oRdAck,
    output logic [127:0] oRdData,
    output logic         oEn,
    output logic [2:0]   oOpReq,
    output logic [22:0]  oOpMemAddr,
    output logic [127:0] oOpMemData,
    input  logic [127:0] iRdData,
    input  logic         iOpDone,
    output logic         oReady,
    output logic         oErr
);

    localparam int POR_W = (POR_CYCLES > 1) ? $clog2(POR_CYCLES) : 1;
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [POR_W-1:0] POR_LAST = POR_W'(POR_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [2:0]         r_state;
    logic [POR_W-1:0]   r_por_cnt;
    logic [TMO_W-1:0]   r_tmo_cnt;
    logic               r_en;
    logic [2:0]         r_op;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_data;
    logic [DATA_W-1:0]  r_rd_data;
    logic               r_wr_ack;
    logic               r_rd_ack;
    logic               r_ready;
    logic               r_err;
    logic               r_gnt_wr;   // granted port of the op in flight
    logic               r_prio_rd;  // tie-break goes to read when set

    logic               w_any_req;
    logic               w_grant_wr;
    logic               w_tmo_hit;
    logic [2:0]         w_stage_op;

    assign w_any_req  = iWrReq | iRdReq;
    // Write wins when alone, or on a tie when read does not hold priority.
    assign w_grant_wr = iWrReq & (~iRdReq | ~r_prio_rd);
    assign w_tmo_hit  = (r_tmo_cnt == TMO_LAST);

    always_comb begin
        w_stage_op = OP_HW_RESET;
        case (r_state)
            ST_INIT_CFG: w_stage_op = OP_WR_REG;
            ST_ISSUE:    w_stage_op = mem_opcode(r_gnt_wr);
            default:     w_stage_op = OP_HW_RESET;
        endcase
    end

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            r_state   <= ST_POR_WAIT;
            r_por_cnt <= '0;
            r_tmo_cnt <= '0;
            r_en      <= 1'b0;
            r_op      <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            r_rd_data <= '0;
            r_wr_ack  <= 1'b0;
            r_rd_ack  <= 1'b0;
            r_ready   <= 1'b0;
            r_err     <= 1'b0;
            r_gnt_wr  <= 1'b0;
            r_prio_rd <= 1'b0;
        end else begin
            r_wr_ack <= 1'b0;
            r_rd_ack <= 1'b0;

            case (r_state)
                ST_POR_WAIT: begin
                    if (r_por_cnt == POR_LAST) begin
                        r_por_cnt <= '0;
                        r_state   <= ST_INIT_RST;
                    end else begin
                        r_por_cnt <= r_por_cnt + 1'b1;
                    end
                end

                // The three op-driving states share one handshake: the
                // first cycle in the state raises oEn and clears the
                // timeout counter; after that, done or timeout ends the op.
                // iOpDone is only looked at while oEn is high.
                ST_INIT_RST, ST_INIT_CFG, ST_ISSUE: begin
                    if (!r_en) begin
                        r_en      <= 1'b1;
                        r_op      <= w_stage_op;
                        r_tmo_cnt <= '0;
                    end else if (iOpDone || w_tmo_hit) begin
                        r_en <= 1'b0;
                        if (!iOpDone) begin
                            r_err <= 1'b1;
                        end
                        case (r_state)
                            ST_INIT_RST: begin
                                if (iOpDone) begin
                                    r_state <= ST_INIT_CFG;
                                end else begin
                                    // A stuck init is abandoned; oErr flags it.
                                    r_ready <= 1'b1;
                                    r_state <= ST_IDLE;
                                end
                            end
                            ST_INIT_CFG: begin
                                r_ready <= 1'b1;
                                r_state <= ST_IDLE;
                            end
                            default: begin
                                if (r_gnt_wr) begin
                                    r_wr_ack <= 1'b1;
                                end else begin
                                    r_rd_ack <= 1'b1;
                                    // On timeout the previous read data is kept.
                                    if (iOpDone) begin
                                        r_rd_data <= iRdData;
                                    end
                                end
                                r_state <= ST_RELEASE;
                            end
                        endcase
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
                end

                ST_IDLE: begin
                    if (w_any_req) begin
                        r_gnt_wr  <= w_grant_wr;
                        r_prio_rd <= w_grant_wr;
                        if (w_grant_wr) begin
                            r_addr <= iWrAddr;
                            r_data <= iWrData;
                        end else begin
                            r_addr <= iRdAddr;
                        end
                        r_state <= ST_ISSUE;
                    end
                end

                // One dead cycle so the acked requester can drop its request
                // before the next arbitration.
                ST_RELEASE: begin
                    r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_POR_WAIT;
                end
            endcase
        end
    end

    assign oEn        = r_en;
    assign oOpReq     = r_op;
    assign oOpMemAddr = r_addr;
    assign oOpMemData = r_data;
    assign oRdData    = r_rd_data;
    assign oWrAck     = r_wr_ack;
    assign oRdAck     = r_rd_ack;
    assign oReady     = r_ready;
    assign oErr       = r_err;

endmodule

// File: tb/tb_hyperram_arbiter.sv
// ---------------------------------------------------------------------------
// tb_hyperram_arbiter
// Scoreboard bench: stimulus pushes expected controller ops and expected
// acks into queues; two monitors pop and compare whenever the DUT raises
// oEn or pulses an ack. A small op-controller model answers with done a
// fixed number of cycles after oEn, or never (timeout case).
// ---------------------------------------------------------------------------
module tb_hyperram_arbiter;
    import hyperram_arbiter_pkg::*;

    localparam int POR = 16;
    localparam int TMO = 64;
    localparam int DLY = 5;

    logic         iClk = 1'b0;
    logic         iRstN = 1'b0;
    logic         iWrReq = 1'b0;
    logic [22:0]  iWrAddr = '0;
    logic [127:0] iWrData = '0;
    logic         oWrAck;
    logic         iRdReq = 1'b0;
    logic [22:0]  iRdAddr = '0;
    logic         oRdAck;
    logic [127:0] oRdData;
    logic         oEn;
    logic [2:0]   oOpReq;
    logic [22:0]  oOpMemAddr;
    logic [127:0] oOpMemData;
    logic [127:0] iRdData = '0;
    logic         iOpDone;
    logic         oReady;
    logic         oErr;

    hyperram_arbiter #(
        .POR_CYCLES     (POR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .iClk       (iClk),
        .iRstN      (iRstN),
        .iWrReq     (iWrReq),
        .iWrAddr    (iWrAddr),
        .iWrData    (iWrData),
        .oWrAck     (oWrAck),
        .iRdReq     (iRdReq),
        .iRdAddr    (iRdAddr),
        .oRdAck     (oRdAck),
        .oRdData    (oRdData),
        .oEn        (oEn),
        .oOpReq     (oOpReq),
        .oOpMemAddr (oOpMemAddr),
        .oOpMemData (oOpMemData),
        .iRdData    (iRdData),
        .iOpDone    (iOpDone),
        .oReady     (oReady),
        .oErr       (oErr)
    );

    always #5 iClk = ~iClk;

    typedef struct {
        logic [2:0]   op;
        logic [22:0]  addr;
        logic [127:0] data;
        bit           chk_addr;
        bit           chk_data;
    } op_t;

    typedef struct {
        bit           is_wr;
        logic [127:0] rdata;
    } ack_t;

    op_t  exp_ops[$];
    ack_t exp_acks[$];
    op_t  mon_op;
    ack_t mon_ack;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fail_now(input string name, input string detail);
        n_checks++;
        $display("FAIL %s: %s", name, detail);
    endtask

    // ---------------- op controller model ----------------
    bit m_hang = 1'b0;
    bit m_spur = 1'b0;
    int m_cnt  = 0;

    initial begin
        iOpDone = 1'b0;
        forever begin
            @(posedge iClk);
            #1;
            if (m_spur) begin
                iOpDone = 1'b1;
                m_spur  = 1'b0;
                m_cnt   = 0;
            end else if (oEn && !m_hang) begin
                m_cnt++;
                iOpDone = (m_cnt == DLY);
            end else begin
                m_cnt   = 0;
                iOpDone = 1'b0;
            end
        end
    end

    // ---------------- op monitor ----------------
    bit prev_en     = 1'b0;
    int cur_len     = 0;
    int last_en_len = 0;

    initial begin
        forever begin
            @(negedge iClk);
            if (oEn && !prev_en) begin
                $display("op   opcode=%b addr=%h data=%h", oOpReq, oOpMemAddr, oOpMemData);
                if (exp_ops.size() == 0) begin
                    fail_now("unexpected_op", "got oEn rise, expected no op pending");
                end else begin
                    mon_op = exp_ops.pop_front();
                    chk("op_opcode", {125'd0, oOpReq}, {125'd0, mon_op.op});
                    if (mon_op.chk_addr) chk("op_addr", {105'd0, oOpMemAddr}, {105'd0, mon_op.addr});
                    if (mon_op.chk_data) chk("op_data", oOpMemData, mon_op.data);
                end
            end
            if (oEn) begin
                cur_len++;
            end else if (prev_en) begin
                last_en_len = cur_len;
                cur_len     = 0;
            end
            prev_en = oEn;
        end
    end

    // ---------------- ack monitor ----------------
    initial begin
        forever begin
            @(negedge iClk);
            if (oWrAck || oRdAck) begin
                $display("ack  wr=%b rd=%b rdata=%h err=%b", oWrAck, oRdAck, oRdData, oErr);
                if (oWrAck && oRdAck) fail_now("both_acks", "got both acks, expected one");
                if (exp_acks.size() == 0) begin
                    fail_now("unexpected_ack", "got ack pulse, expected none");
                end else begin
                    mon_ack = exp_acks.pop_front();
                    chk("ack_port", {127'd0, oWrAck}, {127'd0, mon_ack.is_wr});
                    if (!mon_ack.is_wr) chk("ack_rdata", oRdData, mon_ack.rdata);
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(input bit is_wr, input int budget, output int edges);
        bit done;
        done  = 1'b0;
        edges = 0;
        while (!done) begin
            @(posedge iClk);
            edges++;
            @(negedge iClk);
            if (is_wr ? oWrAck : oRdAck) done = 1'b1;
            else if (edges >= budget) begin
                fail_now("ack_wait", "got no ack within budget, expected ack");
                done = 1'b1;
            end
        end
    endtask

    task automatic release_and_wait_ready(output int edges);
        bit done;
        done  = 1'b0;
        edges = 0;
        iRstN = 1'b1;
        while (!done) begin
            @(posedge iClk);
            edges++;
            @(negedge iClk);
            if (oReady) done = 1'b1;
            else if (edges >= 400) begin
                fail_now("ready_wait", "got oReady=0 after budget, expected 1");
                done = 1'b1;
            end
        end
    endtask

    task automatic push_init_ops();
        exp_ops.push_back('{OP_HW_RESET, 23'd0, 128'd0, 1'b0, 1'b0});
        exp_ops.push_back('{OP_WR_REG,   23'd0, 128'd0, 1'b0, 1'b0});
    endtask

    task automatic do_write(input logic [22:0] a, input logic [127:0] d, output int edges);
        exp_ops.push_back('{OP_WR_MEM, a, d, 1'b1, 1'b1});
        exp_acks.push_back('{1'b1, 128'd0});
        iWrAddr = a;
        iWrData = d;
        iWrReq  = 1'b1;
        wait_ack(1'b1, 300, edges);
        iWrReq  = 1'b0;
        iWrAddr = '0;
        iWrData = '0;
        @(negedge iClk);
    endtask

    task automatic do_read(input logic [22:0] a, input logic [127:0] model_d,
                           input logic [127:0] exp_d, output int edges);
        exp_ops.push_back('{OP_RD_MEM, a, 128'd0, 1'b1, 1'b0});
        exp_acks.push_back('{1'b0, exp_d});
        iRdData = model_d;
        iRdAddr = a;
        iRdReq  = 1'b1;
        wait_ack(1'b0, 300, edges);
        iRdReq  = 1'b0;
        iRdAddr = '0;
        @(negedge iClk);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_en"},    {127'd0, oEn},    128'd0);
        chk({tag, "_op"},    {125'd0, oOpReq}, 128'd0);
        chk({tag, "_addr"},  {105'd0, oOpMemAddr}, 128'd0);
        chk({tag, "_wdata"}, oOpMemData, 128'd0);
        chk({tag, "_rdata"}, oRdData, 128'd0);
        chk({tag, "_acks"},  {126'd0, oWrAck, oRdAck}, 128'd0);
        chk({tag, "_ready"}, {127'd0, oReady}, 128'd0);
        chk({tag, "_err"},   {127'd0, oErr},   128'd0);
    endtask

    localparam logic [127:0] PAT  = 128'h19870901_19861014_20160323_19571112;
    localparam logic [127:0] PAT2 = 128'hA5A5_0001_FFFF_1234_5678_9ABC_DEF0_0F0F;
    localparam logic [127:0] PAT3 = 128'h0BAD_CAFE_0000_1111_2222_3333_4444_5555;
    localparam logic [127:0] JUNK = 128'hDEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD_DEAD;

    // ---------------- main sequence ----------------
    initial begin
        int  e;
        bit  got_wr;
        bit  done;

        repeat (3) @(negedge iClk);
        check_reset_outputs("por");

        // Init: 16 POR edges, 1 raise + 5 done for HW reset, 1 + 5 for config.
        push_init_ops();
        release_and_wait_ready(e);
        chk("init_ready_edges", e, 28);
        chk("init_err", {127'd0, oErr}, 128'd0);

        // Write: grant edge, raise edge, then done on the 5th oEn edge.
        do_write(23'h000008, PAT, e);
        chk("wr_latency", e, 7);
        chk("wr_en_len", last_en_len, DLY);

        // Read returning the same pattern.
        do_read(23'h000008, PAT, PAT, e);
        chk("rd_latency", e, 7);
        chk("rd_data_hold", oRdData, PAT);

        // Stray done while idle must not start or ack anything.
        m_spur = 1'b1;
        repeat (4) @(negedge iClk);
        chk("spur_en", {127'd0, oEn}, 128'd0);
        chk("spur_err", {127'd0, oErr}, 128'd0);

        // Both requesters held: last grant was read, so W,R,W,R.
        for (int k = 0; k < 2; k++) begin
            exp_ops.push_back('{OP_WR_MEM, 23'h7FFFFF, PAT2, 1'b1, 1'b1});
            exp_acks.push_back('{1'b1, 128'd0});
            exp_ops.push_back('{OP_RD_MEM, 23'h000000, 128'd0, 1'b1, 1'b0});
            exp_acks.push_back('{1'b0, PAT3});
        end
        iWrAddr = 23'h7FFFFF;
        iWrData = PAT2;
        iRdAddr = 23'h000000;
        iRdData = PAT3;
        iWrReq  = 1'b1;
        iRdReq  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            done   = 1'b0;
            got_wr = 1'b0;
            for (int c = 0; c < 300 && !done; c++) begin
                @(negedge iClk);
                if (oWrAck || oRdAck) begin
                    done   = 1'b1;
                    got_wr = oWrAck;
                end
            end
            if (!done) fail_now("rr_wait", "got no ack within budget, expected ack");
            chk($sformatf("rr_grant_%0d", k), {127'd0, got_wr}, {127'd0, (k % 2 == 0)});
        end
        iWrReq = 1'b0;
        iRdReq = 1'b0;
        @(negedge iClk);
        @(negedge iClk);

        // Timeout on a read: 64 cycles of oEn, ack, oRdData kept, oErr sticky.
        m_hang = 1'b1;
        do_read(23'h123456, JUNK, PAT3, e);
        m_hang = 1'b0;
        chk("tmo_latency", e, 66);
        chk("tmo_en_len", last_en_len, TMO);
        chk("tmo_err", {127'd0, oErr}, 128'd1);
        chk("tmo_rdata", oRdData, PAT3);

        // Still served after a timeout, error stays set.
        do_write(23'h000010, PAT, e);
        chk("post_tmo_latency", e, 7);
        chk("post_tmo_err", {127'd0, oErr}, 128'd1);

        // Reset in the middle of an issued write: no ack, init reruns.
        exp_ops.push_back('{OP_WR_MEM, 23'h000020, PAT2, 1'b1, 1'b1});
        iWrAddr = 23'h000020;
        iWrData = PAT2;
        iWrReq  = 1'b1;
        repeat (3) @(negedge iClk);
        chk("pre_rst_en", {127'd0, oEn}, 128'd1);
        iRstN  = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        iWrReq = 1'b0;
        repeat (4) @(negedge iClk);
        push_init_ops();
        release_and_wait_ready(e);
        chk("reinit_ready_edges", e, 28);
        repeat (3) @(negedge iClk);
        chk("ops_left", exp_ops.size(), 0);
        chk("acks_left", exp_acks.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global guard so a stuck bench still ends with a report.
    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, expected finish");
        $fatal(1, "global timeout");
    end

endmodule
